sseg_capture_decoder: RTL and testbench
=======================================

# sseg_capture_decoder

Sequential reader for a multiplexed seven-segment display bus: it samples the anode-select and segment lines produced by `BCDtoSSeg` plus the digit scanner, and rebuilds the 4-bit digit codes. It filters scan transitions, decodes each stable segment pattern back to hex, and assembles one frame per complete scan. It sits on the bench side of the display path, where it checks the display driver in simulation and on the board through a logic-analyzer header.

## Interface
Parameters:
- `NDIG`, 4: number of multiplexed digits (anode lines).
- `STABLE_CYC`, 8: number of consecutive identical samples required before a capture (minimum 2).

Ports (reset is asynchronous and active-low):
- `clk`  in  1  single system clock
- `rst`  in  1  asynchronous, active-low reset
- `sseg_in`  in  7  segment lines, active-low, bit6=a … bit0=g (common anode)
- `an_in`  in  NDIG  anode selects, active-low; `an_in[i]` selects digit i
- `digits_o`  out  4*NDIG  decoded frame; digit i in `[4i+3:4i]`
- `frame_o`  out  1  one-cycle pulse when `digits_o` updates
- `valid_o`  out  1  high after the first complete frame, until reset
- `err_o`  out  1  set when the last frame contained an undecodable pattern

## Operation
- **Input synchronizer.** 2-flop synchronizer on `{an_in, sseg_in}`. Reset value is all ones, which reads as blank.
- **Stability filter.** Counter `stab_cnt`, width clog2(STABLE_CYC)+1.
  - If the synchronized sample equals the previous one, the counter increments and saturates.
  - Any difference resets the counter to 0.
- **FSM `S_TRACK`.**
  - When `stab_cnt` reaches STABLE_CYC-1 and the current sample also matches, the sample is stable and a capture event fires. The FSM moves to `S_HELD`.
- **FSM `S_HELD`.**
  - No further captures occur.
  - The FSM returns to `S_TRACK` on the first differing sample.
  - Each stable period yields exactly one capture.
- **Capture event.**
  - **Valid anode.** Exactly one `an_in` bit is low (one-hot-low). Otherwise the event is discarded with no side effects; this covers blanking and overlap.
  - **Decode.** Through the shared table:
    - 0: 0000001, 1: 1001111, 2: 0010010, 3: 0000110, 4: 1001100
    - 5: 0100100, 6: 0100000, 7: 0001111, 8: 0000000, 9: 0000100
    - A: 0001000, b: 1100000, C: 0110001, d: 1000010, E: 0110000, F: 0111000
  - **Write.** Code goes to `shadow[idx]`, and `seen[idx]` is set. A repeated capture of the same idx overwrites it; latest wins.
  - **Invalid pattern.** Any pattern not in the table, blank 1111111 included, writes code 0 and sets the sticky `frame_err`.
- **Frame completion.** When `seen` becomes all ones:
  - next cycle: `digits_o` <= shadow, `frame_o`=1, `valid_o`=1, `err_o` <= `frame_err`
  - `seen` and `frame_err` clear.
  - A capture arriving in the completion cycle belongs to the next frame.

## Timing
- **Reset values.** `digits_o`=0, `frame_o`=0, `valid_o`=0, `err_o`=0, `stab_cnt`=0, `seen`=0, `frame_err`=0, FSM=`S_TRACK`, synchronizer all ones.
- **Capture latency.** The capture edge comes 2 (sync) + STABLE_CYC cycles after a new value appears on the pins.
- **Frame latency.** `frame_o` is asserted 1 cycle after the capture that completes `seen`.
- **Glitches.** Any value held fewer than STABLE_CYC synchronized cycles is never captured.
- **Reset mid-frame.** Partial `seen`/shadow is lost. `digits_o` returns to 0 immediately (asynchronous). The first frame after reset needs all NDIG digits again.
- **`err_o`.** Holds its value between frames and only changes on `frame_o` cycles.

## Structure
- **Package `sseg_pkg`.**
  - `SEG_W`=7 and `CODE_W`=4.
  - The 16-entry active-low segment table as localparam constants, shared with `BCDtoSSeg` verification.
  - FSM state enum `{S_TRACK, S_HELD}`.
- **Sub-module `sseg_pattern_decode`.** Combinational, segment pattern -> {code, hit}, reverse of the table. It is also reusable by other benches.
- **Top.** Contains the synchronizer, filter, FSM, one-hot check with index encode, shadow/seen registers, and frame logic.

## Test plan
- **Reset.** Drive `rst`=0 mid-run -> all outputs 0 within the same time step. `valid_o` stays 0 until the first full frame.
- **Single full frame.** NDIG=4, STABLE_CYC=8. Scan an0..an3 with patterns for 1, 2, 3, 4, 10 cycles each -> `frame_o` pulses once, `digits_o`=16'h4321, `err_o`=0, `valid_o`=1.
- **Glitch rejection.** Insert a 5-cycle 0010010 pulse on digit 0 during a held 1001111 -> digit 0 stays 1. Frame result unchanged.
- **Invalid pattern.** Digit 2 shows 1111111 for 10 cycles in an otherwise valid frame -> `digits_o[11:8]`=0, `err_o`=1 on that `frame_o`. The next clean frame -> `err_o`=0.
- **Anode overlap.** `an_in`=4'b1100 held 12 cycles -> no capture and `seen` unchanged. Blank `an_in`=4'b1111 -> no capture.
- **Overwrite and reset mid-frame.** Digit 0 shows 7, then 9, before the frame completes -> `digits_o[3:0]`=9. Assert reset after 3 digits -> no `frame_o`; a subsequent full scan of A, b, C, d -> `digits_o`=16'hDCBA.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared definitions for seven-segment capture: widths, the active-low
// segment table (common anode, bit6=a .. bit0=g) and the capture FSM states.
package sseg_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CODE_W = 4;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0111000;

  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  typedef enum logic {
    S_TRACK,
    S_HELD
  } cap_state_t;

endpackage

// File: rtl/sseg_capture_decoder_if.sv
// Display-bus bundle: pin-side segment/anode lines and the decoded frame outputs.
interface sseg_capture_decoder_if #(
  parameter int unsigned NDIG = 4
);

  logic [sseg_pkg::SEG_W-1:0]       sseg_in;
  logic [NDIG-1:0]                  an_in;
  logic [sseg_pkg::CODE_W*NDIG-1:0] digits_o;
  logic                             frame_o;
  logic                             valid_o;
  logic                             err_o;

  modport master (
    output sseg_in, an_in,
    input  digits_o, frame_o, valid_o, err_o
  );

  modport slave (
    input  sseg_in, an_in,
    output digits_o, frame_o, valid_o, err_o
  );

endinterface

// File: rtl/sseg_pattern_decode.sv
// Reverse lookup of the segment table: pattern -> {code, hit}.
// Unknown patterns (blank included) return code 0 with hit low.
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  logic [SEG_W-1:0]  seg,
  output logic [CODE_W-1:0] code,
  output logic              hit
);

  always_comb begin
    code = '0;
    hit  = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        code = CODE_W'(i);
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sseg_capture_decoder.sv
// Rebuilds multiplexed seven-segment digits into a frame: synchronise,
// filter for stability, capture once per stable period, assemble per scan.
module sseg_capture_decoder
  import sseg_pkg::*;
#(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned STABLE_CYC = 8
) (
  input logic                   clk,
  input logic                   rst,
  sseg_capture_decoder_if.slave bus
);

  localparam int unsigned SAMP_W = NDIG + SEG_W;
  localparam int unsigned CNT_W  = $clog2(STABLE_CYC) + 1;
  localparam int unsigned IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [SAMP_W-1:0] sync1, sync2, prev;
  logic [CNT_W-1:0]  stab_cnt;
  logic              match;
  logic              capture;

  logic [NDIG-1:0]   an_s;
  logic [SEG_W-1:0]  seg_s;
  logic              an_ok;
  logic [IDX_W-1:0]  an_idx;
  logic [CODE_W-1:0] dec_code;
  logic              dec_hit;

  cap_state_t        state;
  logic [CODE_W-1:0] shadow [NDIG];
  logic [NDIG-1:0]   seen;
  logic              frame_err;

  // All-ones reset makes the pins read as blank with no digit selected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {bus.an_in, bus.sseg_in};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign match = (sync2 == prev);
  assign an_s  = sync2[SAMP_W-1:SEG_W];
  assign seg_s = sync2[SEG_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stab_cnt <= '0;
    end else if (!match) begin
      stab_cnt <= '0;
    end else if (stab_cnt != '1) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  assign capture = (state == S_TRACK) && match &&
                   (stab_cnt == CNT_W'(STABLE_CYC - 1));

  always_comb begin
    int unsigned n_low;
    n_low  = 0;
    an_idx = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (!an_s[i]) begin
        n_low  = n_low + 1;
        an_idx = IDX_W'(i);
      end
    end
    an_ok = (n_low == 1);
  end

  sseg_pattern_decode u_decode (
    .seg  (seg_s),
    .code (dec_code),
    .hit  (dec_hit)
  );

  // Completion clears seen/frame_err first; a capture in the same cycle then
  // lands on top, so it is counted towards the following frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_TRACK;
      seen         <= '0;
      frame_err    <= 1'b0;
      bus.digits_o <= '0;
      bus.frame_o  <= 1'b0;
      bus.valid_o  <= 1'b0;
      bus.err_o    <= 1'b0;
      for (int unsigned i = 0; i < NDIG; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      bus.frame_o <= 1'b0;

      case (state)
        S_TRACK: if (capture) state <= S_HELD;
        S_HELD:  if (!match)  state <= S_TRACK;
        default:              state <= S_TRACK;
      endcase

      if (&seen) begin
        for (int unsigned i = 0; i < NDIG; i++) begin
          bus.digits_o[CODE_W*i +: CODE_W] <= shadow[i];
        end
        bus.frame_o <= 1'b1;
        bus.valid_o <= 1'b1;
        bus.err_o   <= frame_err;
        seen        <= '0;
        frame_err   <= 1'b0;
      end

      if (capture && an_ok) begin
        shadow[an_idx] <= dec_hit ? dec_code : '0;
        seen[an_idx]   <= 1'b1;
        if (!dec_hit) frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_capture_decoder.sv
// Directed bench for sseg_capture_decoder (NDIG=4, STABLE_CYC=8).
module tb_sseg_capture_decoder;

  localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100;
  localparam logic [6:0] P6 = 7'b0100000, P7 = 7'b0001111, P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0000100, PA = 7'b0001000, PB = 7'b1100000;
  localparam logic [6:0] PC = 7'b0110001, PD = 7'b1000010, PE = 7'b0110000;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk = 1'b0;
  logic rst;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned frames = 0;
  int unsigned f0;

  sseg_capture_decoder_if #(.NDIG(4)) bus ();

  sseg_capture_decoder #(.NDIG(4), .STABLE_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_o === 1'b1) frames++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int unsigned n);
    bus.an_in   = an;
    bus.sseg_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    show(4'b1110, s0, 10);
    show(4'b1101, s1, 10);
    show(4'b1011, s2, 10);
    show(4'b0111, s3, 10);
    show(4'b1111, BLANK, 6);
  endtask

  initial begin
    rst         = 1'b0;
    bus.an_in   = 4'b1111;
    bus.sseg_in = BLANK;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits", 32'(bus.digits_o), 32'h0);
    check("rst_frame",  32'(bus.frame_o), 32'h0);
    check("rst_valid",  32'(bus.valid_o), 32'h0);
    check("rst_err",    32'(bus.err_o), 32'h0);
    rst = 1'b1;
    show(4'b1111, BLANK, 12);
    check("idle_valid", 32'(bus.valid_o), 32'h0);

    f0 = frames;
    scan(P1, P2, P3, P4);
    check("single_frames", 32'(frames - f0), 32'd1);
    check("single_digits", 32'(bus.digits_o), 32'h4321);
    check("single_err",    32'(bus.err_o), 32'h0);
    check("single_valid",  32'(bus.valid_o), 32'h1);

    // 5-cycle glitch, then the original pattern too briefly to recapture
    f0 = frames;
    show(4'b1110, P1, 10);
    show(4'b1110, P2, 5);
    show(4'b1110, P1, 6);
    show(4'b1101, P5, 10);
    show(4'b1011, P6, 10);
    show(4'b0111, P7, 10);
    show(4'b1111, BLANK, 6);
    check("glitch_frames", 32'(frames - f0), 32'd1);
    check("glitch_digits", 32'(bus.digits_o), 32'h7651);

    f0 = frames;
    scan(P8, P9, BLANK, PA);
    check("inval_frames", 32'(frames - f0), 32'd1);
    check("inval_digits", 32'(bus.digits_o), 32'hA098);
    check("inval_err",    32'(bus.err_o), 32'h1);
    show(4'b1111, BLANK, 20);
    check("inval_err_hold", 32'(bus.err_o), 32'h1);
    scan(P0, P1, P2, P3);
    check("clean_digits", 32'(bus.digits_o), 32'h3210);
    check("clean_err",    32'(bus.err_o), 32'h0);

    f0 = frames;
    show(4'b1101, P9, 10);
    show(4'b1011, PC, 10);
    show(4'b0111, PD, 10);
    show(4'b1100, P5, 12);
    show(4'b1111, BLANK, 12);
    check("overlap_no_frame", 32'(frames - f0), 32'd0);
    show(4'b1110, PE, 10);
    show(4'b1111, BLANK, 6);
    check("overlap_frames", 32'(frames - f0), 32'd1);
    check("overlap_digits", 32'(bus.digits_o), 32'hDC9E);

    f0 = frames;
    show(4'b1110, P7, 10);
    scan(P9, P1, P2, P3);
    check("overwr_frames", 32'(frames - f0), 32'd1);
    check("overwr_digits", 32'(bus.digits_o), 32'h3219);

    // Partial frame with an invalid digit, then reset before completion
    f0 = frames;
    show(4'b1110, PA, 10);
    show(4'b1101, BLANK, 10);
    show(4'b1011, PC, 10);
    rst = 1'b0;
    #1;
    check("midrst_digits", 32'(bus.digits_o), 32'h0);
    check("midrst_valid",  32'(bus.valid_o), 32'h0);
    check("midrst_err",    32'(bus.err_o), 32'h0);
    check("midrst_frame",  32'(bus.frame_o), 32'h0);
    show(4'b1111, BLANK, 3);
    rst = 1'b1;
    show(4'b0111, PD, 10);
    show(4'b1111, BLANK, 12);
    check("midrst_no_frame", 32'(frames - f0), 32'd0);
    check("midrst_valid_lo", 32'(bus.valid_o), 32'h0);
    scan(PA, PB, PC, PD);
    check("after_rst_frames", 32'(frames - f0), 32'd1);
    check("after_rst_digits", 32'(bus.digits_o), 32'hDCBA);
    check("after_rst_err",    32'(bus.err_o), 32'h0);
    check("after_rst_valid",  32'(bus.valid_o), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
